// File: rtl/accum_seq_pkg.sv
// Shared constants for the accumulator sequencer: instruction fields, opcodes,
// FSM states and the ALU operation select.
package accum_seq_pkg;

  localparam int OPC_MSB = 7;
  localparam int OPC_LSB = 5;
  localparam int OPND_W  = 5;

  typedef enum logic [2:0] {
    OP_NOP = 3'd0,
    OP_LDA = 3'd1,
    OP_STA = 3'd2,
    OP_ADD = 3'd3,
    OP_SUB = 3'd4,
    OP_JMP = 3'd5,
    OP_JZ  = 3'd6,
    OP_HLT = 3'd7
  } opcode_e;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  typedef enum logic {
    ALU_ADD = 1'b0,
    ALU_SUB = 1'b1
  } alu_op_e;

  function automatic opcode_e opc_of(input logic [7:0] instr);
    return opcode_e'(instr[OPC_MSB:OPC_LSB]);
  endfunction

endpackage

// File: rtl/accum_seq_alu.sv
// Combinational add/subtract; c_o is carry-out for ADD and borrow for SUB.
module accum_seq_alu
  import accum_seq_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  alu_op_e           op_i,
  output logic [DATA_W-1:0] y_o,
  output logic              c_o
);

  logic [DATA_W:0] sum;
  logic [DATA_W:0] diff;

  assign sum  = {1'b0, a_i} + {1'b0, b_i};
  // Top bit of the widened difference is set exactly when a_i < b_i.
  assign diff = {1'b0, a_i} - {1'b0, b_i};

  always_comb begin
    y_o = sum[DATA_W-1:0];
    c_o = sum[DATA_W];
    if (op_i == ALU_SUB) begin
      y_o = diff[DATA_W-1:0];
      c_o = diff[DATA_W];
    end
  end

endmodule

// File: rtl/accum_seq_ctrl.sv
// Fetch/decode/execute sequencer driving a shared synchronous memory and the
// accumulator write port. All strobes decode combinationally from state and ir.
module accum_seq_ctrl
  import accum_seq_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic [DATA_W-1:0] acc_data,
  output logic              acc_write,
  output logic [DATA_W-1:0] acc_writedata,
  output logic [ADDR_W-1:0] pc,
  output logic              carry,
  output logic              busy,
  output logic              halted
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic              carry_q, carry_d;

  opcode_e           opc;
  logic [ADDR_W-1:0] opnd;
  alu_op_e           alu_op;
  logic [DATA_W-1:0] alu_y;
  logic              alu_c;

  assign opc    = opc_of(ir_q);
  assign opnd   = ir_q[OPND_W-1:0];
  assign alu_op = (opc == OP_SUB) ? ALU_SUB : ALU_ADD;

  accum_seq_alu #(.DATA_W(DATA_W)) u_alu (
    .a_i  (acc_data),
    .b_i  (mem_rdata),
    .op_i (alu_op),
    .y_o  (alu_y),
    .c_o  (alu_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      carry_q <= carry_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    ir_d          = ir_q;
    carry_d       = carry_q;
    mem_addr      = '0;
    mem_rd        = 1'b0;
    mem_wr        = 1'b0;
    mem_wdata     = '0;
    acc_write     = 1'b0;
    acc_writedata = '0;

    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        mem_addr = pc_q;
        mem_rd   = 1'b1;
        state_d  = S_DECODE;
      end
      S_DECODE: begin
        ir_d    = mem_rdata;
        pc_d    = pc_q + ADDR_W'(1);
        state_d = S_EXEC;
      end
      S_EXEC: begin
        state_d = S_FETCH;
        case (opc)
          OP_LDA, OP_ADD, OP_SUB: begin
            mem_addr = opnd;
            mem_rd   = 1'b1;
            state_d  = S_WB;
          end
          OP_STA: begin
            mem_addr  = opnd;
            mem_wr    = 1'b1;
            mem_wdata = acc_data;
          end
          OP_JMP: pc_d = opnd;
          OP_JZ:  if (acc_data == '0) pc_d = opnd;
          OP_HLT: state_d = S_HALT;
          default: ;
        endcase
      end
      S_WB: begin
        // Operand read in EXEC lands on mem_rdata this cycle.
        acc_write = 1'b1;
        if (opc == OP_LDA) begin
          acc_writedata = mem_rdata;
        end else begin
          acc_writedata = alu_y;
          carry_d       = alu_c;
        end
        state_d = S_FETCH;
      end
      S_HALT: ;
      default: state_d = S_IDLE;
    endcase
  end

  assign pc     = pc_q;
  assign carry  = carry_q;
  assign busy   = (state_q != S_IDLE) && (state_q != S_HALT);
  assign halted = (state_q == S_HALT);

endmodule

// File: tb/tb_accum_seq_ctrl.sv
// Bench for accum_seq_ctrl: memory and accumulator environment, ALU vector
// table, directed corner sequences and random programs vs an ISA-level model.
module tb_accum_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [4:0] mem_addr;
  logic       mem_rd, mem_wr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;
  logic [7:0] acc;
  logic       acc_write;
  logic [7:0] acc_writedata;
  logic [4:0] pc;
  logic       carry, busy, halted;

  logic [7:0] mem [32];
  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  accum_seq_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .mem_addr      (mem_addr),
    .mem_rd        (mem_rd),
    .mem_wr        (mem_wr),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata),
    .acc_data      (acc),
    .acc_write     (acc_write),
    .acc_writedata (acc_writedata),
    .pc            (pc),
    .carry         (carry),
    .busy          (busy),
    .halted        (halted)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // One clock: capture strobes before the edge, update memory/acc just after it.
  task automatic cyc();
    logic rd, wr, aw;
    logic [4:0] a;
    logic [7:0] wd, awd;
    rd = mem_rd; wr = mem_wr; aw = acc_write;
    a = mem_addr; wd = mem_wdata; awd = acc_writedata;
    @(posedge clk); #1;
    if (wr) mem[a] = wd;
    if (rd) mem_rdata = mem[a];
    if (aw) acc = awd;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0;
    cyc(); cyc();
    rst = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1; cyc(); start = 1'b0;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 32; i++) mem[i] = 8'h00;
  endtask

  task automatic wait_halt(input int already, input int exp_cycles, input string nm);
    int n;
    n = already;
    while (!halted && n < 200) begin cyc(); n++; end
    chk(nm, n, exp_cycles);
  endtask

  typedef struct {
    logic [2:0] op;
    logic [7:0] a, b, exp_acc;
    logic       exp_c;
  } vec_t;

  vec_t vecs [7];

  // ISA-level reference: whole instructions on plain variables.
  logic [7:0] m_mem [32];
  logic [7:0] m_acc;
  logic [4:0] m_pc;
  logic       m_c, m_halt;
  int         m_cycles;

  task automatic model_run(input int max_instr);
    logic [7:0] ins, v;
    int n;
    m_pc = 0; m_c = 0; m_halt = 0; m_cycles = 0; n = 0;
    while (!m_halt && n < max_instr) begin
      ins = m_mem[m_pc];
      m_pc = m_pc + 5'd1;
      v = m_mem[ins[4:0]];
      n++;
      case (ins[7:5])
        3'd1: begin m_acc = v; m_cycles += 4; end
        3'd2: begin m_mem[ins[4:0]] = m_acc; m_cycles += 3; end
        3'd3: begin {m_c, m_acc} = {1'b0, m_acc} + {1'b0, v}; m_cycles += 4; end
        3'd4: begin m_c = (m_acc < v); m_acc = m_acc - v; m_cycles += 4; end
        3'd5: begin m_pc = ins[4:0]; m_cycles += 3; end
        3'd6: begin if (m_acc == 0) m_pc = ins[4:0]; m_cycles += 3; end
        3'd7: begin m_halt = 1; m_cycles += 3; end
        default: m_cycles += 3;
      endcase
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; acc = 8'h00; mem_rdata = 8'h00;
    clear_mem();
    @(negedge clk);

    // Reset / idle behaviour
    do_reset();
    repeat (5) cyc();
    chk("idle_busy", busy, 0);
    chk("idle_halted", halted, 0);
    chk("idle_pc", pc, 0);
    chk("idle_strobes", {mem_rd, mem_wr, acc_write}, 0);
    chk("idle_addr", mem_addr, 0);
    chk("idle_carry", carry, 0);
    pulse_start();
    chk("fetch_rd", mem_rd, 1);
    chk("fetch_addr", mem_addr, 0);
    chk("fetch_busy", busy, 1);

    // ALU vector table: LDA 10 ; ADD/SUB 11 ; HLT
    vecs[0] = '{3'd3, 8'hF0, 8'h20, 8'h10, 1'b1};
    vecs[1] = '{3'd4, 8'h05, 8'h07, 8'hFE, 1'b1};
    vecs[2] = '{3'd4, 8'h07, 8'h05, 8'h02, 1'b0};
    vecs[3] = '{3'd3, 8'hFF, 8'h01, 8'h00, 1'b1};
    vecs[4] = '{3'd3, 8'h7F, 8'h01, 8'h80, 1'b0};
    vecs[5] = '{3'd4, 8'h80, 8'h80, 8'h00, 1'b0};
    vecs[6] = '{3'd4, 8'h00, 8'h01, 8'hFF, 1'b1};
    for (int i = 0; i < 7; i++) begin
      do_reset();
      clear_mem();
      mem[0] = 8'h2A; mem[1] = {vecs[i].op, 5'd11}; mem[2] = 8'hE0;
      mem[10] = vecs[i].a; mem[11] = vecs[i].b;
      pulse_start();
      repeat (4) cyc();
      chk($sformatf("v%0d_lda_acc", i), acc, vecs[i].a);
      wait_halt(4, 11, $sformatf("v%0d_halt_cycles", i));
      chk($sformatf("v%0d_acc", i), acc, vecs[i].exp_acc);
      chk($sformatf("v%0d_carry", i), carry, vecs[i].exp_c);
      chk($sformatf("v%0d_pc", i), pc, 3);
    end

    // Store then JZ, taken and not taken
    for (int k = 0; k < 2; k++) begin
      do_reset();
      clear_mem();
      mem[0] = 8'h54; mem[1] = 8'hC5; mem[20] = 8'hAA;
      acc = (k == 0) ? 8'h00 : 8'h01;
      pulse_start();
      cyc(); cyc();
      chk($sformatf("sta%0d_wr", k), {mem_wr, mem_rd}, 2'b10);
      chk($sformatf("sta%0d_addr", k), mem_addr, 20);
      chk($sformatf("sta%0d_wdata", k), mem_wdata, acc);
      repeat (4) cyc();
      chk($sformatf("sta%0d_mem", k), mem[20], (k == 0) ? 8'h00 : 8'h01);
      chk($sformatf("jz%0d_pc", k), pc, (k == 0) ? 5 : 2);
    end

    // PC wrap: JMP 31 then NOP at 31
    do_reset();
    clear_mem();
    mem[0] = 8'hBF;
    pulse_start();
    repeat (3) cyc();
    chk("wrap_pc31", pc, 31);
    chk("wrap_fetch31", {mem_rd, mem_addr}, {1'b1, 5'd31});
    repeat (3) cyc();
    chk("wrap_pc0", pc, 0);
    chk("wrap_fetch0", {mem_rd, mem_addr}, {1'b1, 5'd0});

    // Reset during WB of ADD
    do_reset();
    clear_mem();
    acc = 8'h00;
    mem[0] = 8'h2A; mem[1] = 8'h6B; mem[10] = 8'hF0; mem[11] = 8'h20;
    pulse_start();
    repeat (7) cyc();
    chk("mid_wb_write", acc_write, 1);
    chk("mid_wb_data", acc_writedata, 8'h10);
    rst = 1'b1;
    cyc();
    chk("mid_rst_strobes", {acc_write, mem_rd, mem_wr}, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_pc", pc, 0);
    chk("mid_rst_carry", carry, 0);
    rst = 1'b0;
    cyc();
    chk("mid_rst_idle", {busy, halted}, 0);

    // HALT ignores start, leaves only on reset
    do_reset();
    clear_mem();
    mem[0] = 8'hE0;
    pulse_start();
    wait_halt(0, 3, "hlt_cycles");
    pulse_start();
    repeat (3) cyc();
    chk("hlt_stays", {halted, busy, mem_rd, mem_wr, acc_write}, 5'b10000);
    chk("hlt_pc", pc, 1);
    rst = 1'b1; cyc(); rst = 1'b0;
    chk("hlt_rst", halted, 0);

    // Random programs against the ISA model
    for (int t = 0; t < 25; t++) begin
      logic [7:0] a0;
      for (int i = 0; i < 32; i++) m_mem[i] = 8'($urandom);
      a0 = 8'($urandom);
      m_acc = a0;
      do_reset();
      for (int i = 0; i < 32; i++) mem[i] = m_mem[i];
      acc = a0;
      model_run(25);
      pulse_start();
      repeat (m_cycles) cyc();
      chk($sformatf("r%0d_pc", t), pc, m_pc);
      chk($sformatf("r%0d_acc", t), acc, m_acc);
      chk($sformatf("r%0d_carry", t), carry, m_c);
      chk($sformatf("r%0d_halted", t), {halted, busy}, {m_halt, !m_halt});
      for (int i = 0; i < 32; i++)
        chk($sformatf("r%0d_mem%0d", t, i), mem[i], m_mem[i]);
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
